soc_mem_arb: RTL

Parametrised memory subsystem for the next-generation SoPC top: replaces separate instruction and data memories with one unified single-port word RAM. The CPU instruction port and data port share it through a request/acknowledge handshake. Data accesses have fixed priority, and a starvation guard protects instruction fetch. Read latency and memory depth are configurable, so the CPU stalls on the acks instead of relying on zero-wait combinational memories.

---
 rtl/soc_pkg.sv | 25 ++
 rtl/ram_sp.sv | 47 ++++
 rtl/soc_mem_arb.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/soc_pkg.sv
// Shared types and helpers for the unified memory subsystem and the future cache.
package soc_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
    typedef enum logic {GNT_IM, GNT_DM} gnt_t;

    // Overlay the enabled byte lanes of new_word onto old_word.
    function automatic logic [WORD_W-1:0] lane_merge(
        input logic [WORD_W-1:0] old_word,
        input logic [WORD_W-1:0] new_word,
        input logic [3:0]        be
    );
        logic [WORD_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/ram_sp.sv
// Single-port word RAM built from four byte-lane arrays, with an RD_LAT-stage read pipeline.
module ram_sp
    import soc_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int RD_LAT      = 1,
    parameter int AW          = 10
) (
    input  logic              clk,
    input  logic [AW-1:0]     addr,
    input  logic [3:0]        we,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] rd_raw;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH_WORDS];

            always_ff @(posedge clk) begin
                if (we[gi]) begin
                    mem[addr] <= wdata[8*gi +: 8];
                end
                rd_raw[8*gi +: 8] <= mem[addr];
            end
        end

        if (RD_LAT == 1) begin : g_lat1
            assign rdata = rd_raw;
        end else begin : g_latn
            logic [WORD_W-1:0] pipe [RD_LAT-1];

            always_ff @(posedge clk) begin
                pipe[0] <= rd_raw;
                for (int i = 1; i < RD_LAT - 1; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end

            assign rdata = pipe[RD_LAT-2];
        end
    endgenerate

endmodule

// File: rtl/soc_mem_arb.sv
// Instruction/data arbiter in front of one unified single-port RAM, with an
// instruction-fetch starvation guard and out-of-range detection.
module soc_mem_arb
    import soc_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int RD_LAT      = 1,
    parameter int STARVE_MAX  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        im_req,
    input  logic [31:0] im_addr,
    output logic [31:0] im_out,
    output logic        im_ack,
    input  logic        dm_req,
    input  logic [3:0]  dm_byte,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_in,
    output logic [31:0] dm_out,
    output logic        dm_ack,
    output logic        err
);

    localparam int         AW         = $clog2(DEPTH_WORDS);
    localparam logic [2:0] LAT_LAST   = 3'(RD_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state_reg, state_next;
    gnt_t              gnt_reg, gnt_sel;
    logic [AW-1:0]     idx_reg;
    logic              oor_reg;
    logic [3:0]        be_reg;
    logic [WORD_W-1:0] wdata_reg;
    logic [3:0]        starve_reg;
    logic [2:0]        lat_reg;

    logic              any_req;
    logic [29:0]       word_sel;
    logic              oor_sel;
    logic              is_write;
    logic              last_access;
    logic [AW-1:0]     ram_addr;
    logic [3:0]        ram_we;
    logic [WORD_W-1:0] ram_rdata;
    logic [WORD_W-1:0] rd_word;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{im_addr[1:0], dm_addr[1:0]};

    assign any_req = im_req | dm_req;

    always_comb begin
        gnt_sel = GNT_IM;
        if (dm_req && !(im_req && starve_reg == STARVE_LIM)) begin
            gnt_sel = GNT_DM;
        end
    end

    assign word_sel = (gnt_sel == GNT_DM) ? dm_addr[31:2] : im_addr[31:2];
    assign oor_sel  = |word_sel[29:AW];

    assign is_write    = (gnt_reg == GNT_DM) && (be_reg != 4'b0);
    assign last_access = (state_reg == ACCESS) && (is_write || lat_reg == LAT_LAST);

    // The read is launched from IDLE so RD_LAT pipeline stages land exactly on the last ACCESS cycle.
    assign ram_addr = (state_reg == IDLE) ? word_sel[AW-1:0] : idx_reg;
    // Gated by rst so a reset landing on the write edge aborts the write.
    assign ram_we   = (state_reg == ACCESS && is_write && !oor_reg && rst) ? be_reg : 4'b0;
    assign rd_word  = (is_write || oor_reg) ? '0 : ram_rdata;

    ram_sp #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .RD_LAT      (RD_LAT),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (wdata_reg),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_req) state_next = ACCESS;
            ACCESS:  if (last_access) state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= IDLE;
            gnt_reg    <= GNT_IM;
            idx_reg    <= '0;
            oor_reg    <= 1'b0;
            be_reg     <= 4'b0;
            wdata_reg  <= '0;
            starve_reg <= 4'd0;
            lat_reg    <= 3'd0;
            im_ack     <= 1'b0;
            dm_ack     <= 1'b0;
            err        <= 1'b0;
            im_out     <= '0;
            dm_out     <= '0;
        end else begin
            state_reg <= state_next;
            im_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            err       <= 1'b0;

            if (state_reg == IDLE && any_req) begin
                gnt_reg   <= gnt_sel;
                idx_reg   <= word_sel[AW-1:0];
                oor_reg   <= oor_sel;
                be_reg    <= (gnt_sel == GNT_DM) ? dm_byte : 4'b0;
                wdata_reg <= dm_in;
                // Count only data grants that made a waiting fetch wait longer.
                if (gnt_sel == GNT_DM && im_req) begin
                    if (starve_reg != STARVE_LIM) begin
                        starve_reg <= starve_reg + 4'd1;
                    end
                end else begin
                    starve_reg <= 4'd0;
                end
            end

            if (state_reg == ACCESS) begin
                if (last_access) begin
                    lat_reg <= 3'd0;
                    err     <= oor_reg;
                    if (gnt_reg == GNT_IM) begin
                        im_ack <= 1'b1;
                        im_out <= rd_word;
                    end else begin
                        dm_ack <= 1'b1;
                        dm_out <= rd_word;
                    end
                end else begin
                    lat_reg <= lat_reg + 3'd1;
                end
            end
        end
    end

endmodule
